// File: rtl/exec_issue_sequencer_if.sv
// Issue-side bus between the sequencer and its neighbours: instruction
// handshake, execution-unit operands/results and the writeback strobe.
interface exec_issue_sequencer_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_src1;
  logic [15:0] ex_src2;
  logic [15:0] ex_immediate;
  logic [15:0] ex_result;
  logic        ex_zero;
  logic        ex_carry;
  logic        ex_div_done;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  // Handshake: an instruction transfers at a rising edge where
  // instr_valid && instr_ready; the sender holds instr stable until then.
  modport master (
    input  instr_valid, instr, ex_result, ex_zero, ex_carry, ex_div_done,
    output instr_ready, ex_opcode, ex_src1, ex_src2, ex_immediate,
           wb_valid, wb_addr, wb_data
  );

  modport slave (
    output instr_valid, instr, ex_result, ex_zero, ex_carry, ex_div_done,
    input  instr_ready, ex_opcode, ex_src1, ex_src2, ex_immediate,
           wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/exec_issue_sequencer.sv
// Single-issue sequencer: decode, operand fetch from an 8x16 register file,
// fixed-latency execution-unit handoff, then writeback and flag update.
module exec_issue_sequencer #(
  parameter int          EXEC_CYCLES = 1,
  parameter logic [3:0]  DIV_OPCODE  = 4'b0011,
  parameter logic [3:0]  NOP_OPCODE  = 4'b1111
) (
  input  logic                   clk,
  input  logic                   rst,
  exec_issue_sequencer_if.master bus,
  output logic                   zero_q,
  output logic                   carry_q,
  output logic                   div_error,
  output logic                   busy,
  input  logic [2:0]             dbg_addr,
  output logic [15:0]            dbg_data,
  output logic [1:0]             dbg_state
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t          state;
  logic [15:0]     instr_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]      op_q;
  logic [15:0]     src1_q;
  logic [15:0]     src2_q;
  logic [15:0]     imm_q;
  logic            zero_lat;
  logic            carry_lat;
  logic            wb_valid_q;
  logic [2:0]      wb_addr_q;
  logic [15:0]     wb_data_q;
  logic [15:0]     rf [0:7];

  logic            is_nop;
  logic            div_reject;

  assign bus.instr_ready  = (state == IDLE) & ~rst;
  assign bus.ex_opcode    = op_q;
  assign bus.ex_src1      = src1_q;
  assign bus.ex_src2      = src2_q;
  assign bus.ex_immediate = imm_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_addr      = wb_addr_q;
  assign bus.wb_data      = wb_data_q;

  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign dbg_data  = (dbg_addr == 3'd0) ? 16'h0000 : rf[dbg_addr];

  // Writeback decision is taken from the execution-unit outputs at the
  // sampling edge, so the WB cycle already presents the final strobes.
  assign is_nop     = (op_q == NOP_OPCODE);
  assign div_reject = (op_q == DIV_OPCODE) & ~bus.ex_div_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      instr_q    <= 16'h0000;
      cnt        <= '0;
      op_q       <= 4'h0;
      src1_q     <= 16'h0000;
      src2_q     <= 16'h0000;
      imm_q      <= 16'h0000;
      zero_lat   <= 1'b0;
      carry_lat  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 3'd0;
      wb_data_q  <= 16'h0000;
      div_error  <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf[i] <= 16'h0000;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            state   <= READ;
          end
        end
        READ: begin
          op_q   <= instr_q[15:12];
          src1_q <= rf[instr_q[8:6]];
          src2_q <= rf[instr_q[5:3]];
          imm_q  <= {{10{instr_q[5]}}, instr_q[5:0]};
          cnt    <= CNT_W'(EXEC_CYCLES - 1);
          state  <= EXEC;
        end
        EXEC: begin
          if (cnt == '0) begin
            zero_lat   <= bus.ex_zero;
            carry_lat  <= bus.ex_carry;
            wb_addr_q  <= instr_q[11:9];
            wb_data_q  <= bus.ex_result;
            wb_valid_q <= ~is_nop & ~div_reject;
            div_error  <= div_reject;
            state      <= WB;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WB: begin
          // r0 is hardwired to zero; the strobe still fires for it.
          if (wb_valid_q) begin
            if (wb_addr_q != 3'd0) begin
              rf[wb_addr_q] <= wb_data_q;
            end
            zero_q  <= zero_lat;
            carry_q <= carry_lat;
          end
          wb_valid_q <= 1'b0;
          div_error  <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
